// File: rtl/cpu_bus_pkg.sv
// -----------------------------------------------------------------------------
// cpu_bus_pkg
// Shared definitions for the CPU/DMA RAM-port arbiter:
//   arb_state_t             - arbiter state, 2-bit encoding
//   DEFAULT_MAX_BURST       - default maximum DMA transfers per grant
//   DEFAULT_CPU_MIN_CYCLES  - default guaranteed CPU run between bursts
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package cpu_bus_pkg;

   typedef enum logic [1:0] {
      CPU_OWN = 2'b00,
      DRAIN   = 2'b01,
      DMA_OWN = 2'b10,
      RESTORE = 2'b11
   } arb_state_t;

   localparam int DEFAULT_MAX_BURST      = 16;
   localparam int DEFAULT_CPU_MIN_CYCLES = 8;

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// cpu_bus_arbiter_if
// Bundles the CPU side, DMA side and RAM side of the arbiter.
//   slave  : view taken by the arbiter (consumes CPU/DMA requests and RAM
//            read data, drives RAM address/data/we, RDY, grant, read data).
//   master : view taken by the surrounding system (CPU, DMA engine, RAM).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface cpu_bus_arbiter_if;

   // CPU side
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_we;
   logic        cpu_rdy;
   logic [7:0]  cpu_rdata;

   // DMA side
   logic        dma_req;
   logic [15:0] dma_addr;
   logic [7:0]  dma_wdata;
   logic        dma_we;
   logic        dma_gnt;
   logic [7:0]  dma_rdata;
   logic        dma_rvalid;

   // RAM side
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic [7:0]  mem_rdata;

   modport slave (
      input  cpu_addr, cpu_wdata, cpu_we,
      output cpu_rdy, cpu_rdata,
      input  dma_req, dma_addr, dma_wdata, dma_we,
      output dma_gnt, dma_rdata, dma_rvalid,
      output mem_addr, mem_wdata, mem_we,
      input  mem_rdata
   );

   modport master (
      output cpu_addr, cpu_wdata, cpu_we,
      input  cpu_rdy, cpu_rdata,
      output dma_req, dma_addr, dma_wdata, dma_we,
      input  dma_gnt, dma_rdata, dma_rvalid,
      input  mem_addr, mem_wdata, mem_we,
      output mem_rdata
   );

endinterface

// File: rtl/cpu_bus_mux.sv
// -----------------------------------------------------------------------------
// cpu_bus_mux
// Combinational RAM-port multiplexer selected by the arbiter state.
//   state                       in  current arbiter state
//   cpu_addr/cpu_wdata/cpu_we   in  CPU request
//   dma_req/dma_addr/
//   dma_wdata/dma_we            in  DMA request
//   mem_addr/mem_wdata/mem_we   out RAM port
// Only DMA_OWN routes the DMA engine to RAM; every other state shows the
// CPU address. Writes are suppressed in DRAIN and RESTORE, where the CPU is
// stalled but its address must stay on the bus to (re)fetch read data.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module cpu_bus_mux
   import cpu_bus_pkg::*;
(
   input  arb_state_t  state,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   input  logic        cpu_we,
   input  logic        dma_req,
   input  logic [15:0] dma_addr,
   input  logic [7:0]  dma_wdata,
   input  logic        dma_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   output logic        mem_we
);

   always_comb begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_we    = 1'b0;
      case (state)
         CPU_OWN: mem_we = cpu_we;
         DMA_OWN: begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            // A low request cycle is not a transfer, so it must not write.
            mem_we    = dma_we & dma_req;
         end
         default: mem_we = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_bus_arbiter
// Shares one synchronous-read RAM port between the 6502 core and a DMA
// requester. The CPU owns the bus by default; the DMA engine gets bounded
// bursts by stalling the CPU through RDY, and a fairness counter guarantees
// the CPU a run of cycles between bursts.
// Parameters:
//   MAX_BURST       maximum DMA transfers per grant (1..255)
//   CPU_MIN_CYCLES  CPU-owned cycles loaded after each burst (0..255)
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  synchronous, active-low reset
//   bus    slave view of cpu_bus_arbiter_if (CPU, DMA and RAM signals)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module cpu_bus_arbiter
   import cpu_bus_pkg::*;
#(
   parameter int MAX_BURST      = DEFAULT_MAX_BURST,
   parameter int CPU_MIN_CYCLES = DEFAULT_CPU_MIN_CYCLES
) (
   input  logic               clk,
   input  logic               reset,
   cpu_bus_arbiter_if.slave   bus
);

   localparam logic [7:0] LAST_XFER = 8'(MAX_BURST - 1);
   localparam logic [7:0] FAIR_LOAD = 8'(CPU_MIN_CYCLES);

   arb_state_t state_reg;
   logic       cpu_rdy_reg;
   logic       dma_gnt_reg;
   logic       dma_rvalid_reg;
   logic [7:0] burst_cnt_reg;
   logic [7:0] fair_cnt_reg;
   logic       arbitrate;

   // A CPU write cycle is never interrupted: arbitration simply waits for a
   // non-write cycle, which also keeps DMA addresses off the bus while WE=1.
   assign arbitrate = bus.dma_req & ~bus.cpu_we & (fair_cnt_reg == 8'd0);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg      <= CPU_OWN;
         cpu_rdy_reg    <= 1'b1;
         dma_gnt_reg    <= 1'b0;
         dma_rvalid_reg <= 1'b0;
         burst_cnt_reg  <= 8'd0;
         fair_cnt_reg   <= 8'd0;
      end else begin
         // Read data returns one cycle after the address, so validity is
         // simply the previous cycle's DMA read strobe.
         dma_rvalid_reg <= (state_reg == DMA_OWN) & bus.dma_req & ~bus.dma_we;
         case (state_reg)
            CPU_OWN: begin
               if (fair_cnt_reg != 8'd0) begin
                  fair_cnt_reg <= fair_cnt_reg - 8'd1;
               end
               if (arbitrate) begin
                  state_reg   <= DRAIN;
                  cpu_rdy_reg <= 1'b0;
               end
            end
            DRAIN: begin
               state_reg     <= DMA_OWN;
               dma_gnt_reg   <= 1'b1;
               burst_cnt_reg <= 8'd0;
            end
            DMA_OWN: begin
               if (!bus.dma_req) begin
                  state_reg   <= RESTORE;
                  dma_gnt_reg <= 1'b0;
               end else begin
                  burst_cnt_reg <= burst_cnt_reg + 8'd1;
                  if (burst_cnt_reg == LAST_XFER) begin
                     state_reg   <= RESTORE;
                     dma_gnt_reg <= 1'b0;
                  end
               end
            end
            RESTORE: begin
               state_reg    <= CPU_OWN;
               cpu_rdy_reg  <= 1'b1;
               fair_cnt_reg <= FAIR_LOAD;
            end
            default: state_reg <= CPU_OWN;
         endcase
      end
   end

   cpu_bus_mux u_mux (
      .state     (state_reg),
      .cpu_addr  (bus.cpu_addr),
      .cpu_wdata (bus.cpu_wdata),
      .cpu_we    (bus.cpu_we),
      .dma_req   (bus.dma_req),
      .dma_addr  (bus.dma_addr),
      .dma_wdata (bus.dma_wdata),
      .dma_we    (bus.dma_we),
      .mem_addr  (bus.mem_addr),
      .mem_wdata (bus.mem_wdata),
      .mem_we    (bus.mem_we)
   );

   assign bus.cpu_rdy    = cpu_rdy_reg;
   assign bus.dma_gnt    = dma_gnt_reg;
   assign bus.dma_rvalid = dma_rvalid_reg;
   assign bus.cpu_rdata  = bus.mem_rdata;
   assign bus.dma_rdata  = bus.mem_rdata;

endmodule
